// File: rtl/cmd_responder.sv
// Command consumer/responder behind UART_comm: applies set-point opcodes, sequences
// calibration and answers every frame with one response byte. Optional: CMD_TIMEOUT_EN.
module cmd_responder #(
   parameter logic [25:0] TMO_CYCLES = 26'd67_108_863,
   parameter logic [7:0]  ACK_BYTE   = 8'hA5,
   parameter logic [7:0]  NAK_BYTE   = 8'hEE
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_rdy_i,
   input  logic [7:0]  cmd_i,
   input  logic [15:0] data_i,
   output logic        clr_cmd_rdy_o,
   output logic [7:0]  resp_o,
   output logic        send_resp_o,
   input  logic        resp_sent_i,
   input  logic        cal_done_i,
   output logic        strt_cal_o,
   output logic        inertial_cal_o,
   output logic [15:0] d_ptch_o,
   output logic [15:0] d_roll_o,
   output logic [15:0] d_yaw_o,
   output logic [8:0]  thrst_o,
   output logic        motors_off_o
);

   typedef enum logic [1:0] {IDLE, CAL_WAIT, SEND, RESP_WAIT} state_t;

   localparam logic [7:0] OP_PTCH  = 8'h02;
   localparam logic [7:0] OP_ROLL  = 8'h03;
   localparam logic [7:0] OP_YAW   = 8'h04;
   localparam logic [7:0] OP_THRST = 8'h05;
   localparam logic [7:0] OP_CAL   = 8'h06;
   localparam logic [7:0] OP_EMER  = 8'h07;
   localparam logic [7:0] OP_MOFF  = 8'h08;

   state_t      state_q, state_d;
   logic        clr_q, clr_d;
   logic        send_q, send_d;
   logic        strt_q, strt_d;
   logic        ical_q, ical_d;
   logic        nak_q, nak_d;
   logic        moff_q, moff_d;
   logic        sent_q;
   logic [7:0]  resp_q, resp_d;
   logic [15:0] ptch_q, ptch_d;
   logic [15:0] roll_q, roll_d;
   logic [15:0] yaw_q, yaw_d;
   logic [8:0]  thrst_q, thrst_d;
   logic        consume;
   logic        sent_rise;

`ifdef CMD_TIMEOUT_EN
   logic [25:0] tmo_q, tmo_d;
`else
   logic unused_tmo;
   assign unused_tmo = ^TMO_CYCLES;
`endif

   // Completion is an edge, so a level left high from a previous response is not taken as done.
   assign sent_rise = resp_sent_i & ~sent_q;

   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      send_d  = 1'b0;
      strt_d  = 1'b0;
      ical_d  = ical_q;
      nak_d   = nak_q;
      moff_d  = moff_q;
      resp_d  = resp_q;
      ptch_d  = ptch_q;
      roll_d  = roll_q;
      yaw_d   = yaw_q;
      thrst_d = thrst_q;
      consume = 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_rdy_i) begin
               consume = 1'b1;
               clr_d   = 1'b1;
               nak_d   = 1'b0;
               state_d = SEND;
               case (cmd_i)
                  OP_PTCH:  ptch_d  = data_i;
                  OP_ROLL:  roll_d  = data_i;
                  OP_YAW:   yaw_d   = data_i;
                  OP_THRST: thrst_d = data_i[8:0];
                  OP_CAL: begin
                     moff_d  = 1'b0;
                     strt_d  = 1'b1;
                     ical_d  = 1'b1;
                     state_d = CAL_WAIT;
                  end
                  OP_EMER: begin
                     ptch_d  = 16'h0000;
                     roll_d  = 16'h0000;
                     yaw_d   = 16'h0000;
                     thrst_d = 9'h000;
                  end
                  OP_MOFF:  moff_d  = 1'b1;
                  default:  nak_d   = 1'b1;
               endcase
            end
         end
         CAL_WAIT: begin
            if (cal_done_i) begin
               ical_d  = 1'b0;
               state_d = SEND;
            end
         end
         SEND: begin
            send_d  = 1'b1;
            resp_d  = nak_q ? NAK_BYTE : ACK_BYTE;
            state_d = RESP_WAIT;
         end
         RESP_WAIT: begin
            if (sent_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef CMD_TIMEOUT_EN
      // A consumed frame wins over the timeout in the same edge; once reached, the count holds.
      if (consume) begin
         tmo_d = 26'd0;
      end else begin
         if (tmo_q != TMO_CYCLES) tmo_d = tmo_q + 26'd1;
         if (tmo_d == TMO_CYCLES) begin
            moff_d  = 1'b1;
            thrst_d = 9'h000;
         end
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         clr_q   <= 1'b0;
         send_q  <= 1'b0;
         strt_q  <= 1'b0;
         ical_q  <= 1'b0;
         nak_q   <= 1'b0;
         moff_q  <= 1'b1;
         sent_q  <= 1'b0;
         resp_q  <= 8'h00;
         ptch_q  <= 16'h0000;
         roll_q  <= 16'h0000;
         yaw_q   <= 16'h0000;
         thrst_q <= 9'h000;
`ifdef CMD_TIMEOUT_EN
         tmo_q   <= 26'd0;
`endif
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         send_q  <= send_d;
         strt_q  <= strt_d;
         ical_q  <= ical_d;
         nak_q   <= nak_d;
         moff_q  <= moff_d;
         sent_q  <= resp_sent_i;
         resp_q  <= resp_d;
         ptch_q  <= ptch_d;
         roll_q  <= roll_d;
         yaw_q   <= yaw_d;
         thrst_q <= thrst_d;
`ifdef CMD_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign clr_cmd_rdy_o  = clr_q;
   assign send_resp_o    = send_q;
   assign strt_cal_o     = strt_q;
   assign inertial_cal_o = ical_q;
   assign motors_off_o   = moff_q;
   assign resp_o         = resp_q;
   assign d_ptch_o       = ptch_q;
   assign d_roll_o       = roll_q;
   assign d_yaw_o        = yaw_q;
   assign thrst_o        = thrst_q;

endmodule

// File: tb/tb_cmd_responder.sv
// Self-checking bench for cmd_responder: directed frames, busy/stale-handshake cases,
// random frames against a set-point model, mid-calibration reset, timeout when CMD_TIMEOUT_EN.
module tb_cmd_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_rdy = 1'b0;
   logic [7:0]  cmd = 8'h00;
   logic [15:0] data = 16'h0000;
   logic        resp_sent = 1'b0;
   logic        cal_done = 1'b0;
   logic        clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off;
   logic [7:0]  resp;
   logic [15:0] d_ptch, d_roll, d_yaw;
   logic [8:0]  thrst;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int clr_cyc = 0;

   // reference state
   logic [15:0] m_ptch, m_roll, m_yaw;
   logic [8:0]  m_thrst;
   logic        m_moff;
   logic [7:0]  m_resp;

   cmd_responder #(.TMO_CYCLES(26'd1000), .ACK_BYTE(8'hA5), .NAK_BYTE(8'hEE)) dut (
      .clk_i(clk), .rst_i(rst), .cmd_rdy_i(cmd_rdy), .cmd_i(cmd), .data_i(data),
      .clr_cmd_rdy_o(clr_cmd_rdy), .resp_o(resp), .send_resp_o(send_resp),
      .resp_sent_i(resp_sent), .cal_done_i(cal_done), .strt_cal_o(strt_cal),
      .inertial_cal_o(inertial_cal), .d_ptch_o(d_ptch), .d_roll_o(d_roll),
      .d_yaw_o(d_yaw), .thrst_o(thrst), .motors_off_o(motors_off)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptch = 16'h0; m_roll = 16'h0; m_yaw = 16'h0; m_thrst = 9'h0; m_moff = 1'b1; m_resp = 8'h00;
   endtask

   task automatic model_apply(input logic [7:0] op, input logic [15:0] dat);
      m_resp = 8'hA5;
      case (op)
         8'h02: m_ptch = dat;
         8'h03: m_roll = dat;
         8'h04: m_yaw = dat;
         8'h05: m_thrst = dat[8:0];
         8'h06: m_moff = 1'b0;
         8'h07: begin m_ptch = 16'h0; m_roll = 16'h0; m_yaw = 16'h0; m_thrst = 9'h0; end
         8'h08: m_moff = 1'b1;
         default: m_resp = 8'hEE;
      endcase
   endtask

   task automatic check_setpoints(input string tag);
      check({tag, ".ptch"}, d_ptch, m_ptch);
      check({tag, ".roll"}, d_roll, m_roll);
      check({tag, ".yaw"}, d_yaw, m_yaw);
      check({tag, ".thrst"}, thrst, m_thrst);
      check({tag, ".moff"}, motors_off, m_moff);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_setpoints(tag);
      check({tag, ".resp"}, resp, 8'h00);
      check({tag, ".clr"}, clr_cmd_rdy, 1'b0);
      check({tag, ".send"}, send_resp, 1'b0);
      check({tag, ".strt"}, strt_cal, 1'b0);
      check({tag, ".ical"}, inertial_cal, 1'b0);
   endtask

   // one full frame: present, consume, (calibrate), respond, acknowledge
   task automatic do_cmd(input logic [7:0] op, input logic [15:0] dat, input int cal_dly, input int sent_dly);
      int n;
      logic busy_send;
      @(negedge clk); cmd_rdy = 1'b1; cmd = op; data = dat;
      n = 0;
      do begin @(negedge clk); n++; end while (!clr_cmd_rdy && n < 20);
      check("clr_latency", n, 1);
      clr_cyc = cyc;
      cmd_rdy = 1'b0;
      model_apply(op, dat);
      check_setpoints("apply");
      check("strt_cal", strt_cal, (op == 8'h06));
      check("ical_start", inertial_cal, (op == 8'h06));
      if (op == 8'h06) begin
         busy_send = 1'b0;
         repeat (cal_dly) begin @(negedge clk); busy_send |= send_resp | strt_cal; end
         check("cal_quiet", busy_send, 1'b0);
         check("ical_hold", inertial_cal, 1'b1);
         cal_done = 1'b1; @(negedge clk); cal_done = 1'b0;
         check("ical_done", inertial_cal, 1'b0);
      end
      @(negedge clk);
      check("send_resp", send_resp, 1'b1);
      check("resp", resp, m_resp);
      @(negedge clk);
      check("send_pulse", send_resp, 1'b0);
      cal_done = 1'b1; @(negedge clk); cal_done = 1'b0;
      check("stray_cal_done", inertial_cal, 1'b0);
      repeat (sent_dly) @(negedge clk);
      resp_sent = 1'b1; @(negedge clk); resp_sent = 1'b0;
   endtask

   initial begin
      logic        seen;
      logic [7:0]  op;
      logic [15:0] dat;
      int          r;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // directed frames
      do_cmd(8'h05, 16'h01F4, 0, 2);
      check("thrst_1F4", thrst, 9'h1F4);
      do_cmd(8'h06, 16'h0000, 100, 3);
      check("cal_moff", motors_off, 1'b0);
      do_cmd(8'h02, 16'hFF9C, 0, 1);
      check("ptch_neg100", $signed(d_ptch), -100);
      do_cmd(8'h03, 16'h7FFF, 0, 1);
      do_cmd(8'h04, 16'h8000, 0, 1);
      do_cmd(8'h07, 16'h1234, 0, 1);
      do_cmd(8'h3C, 16'hBEEF, 0, 2);
      do_cmd(8'h05, 16'hFE64, 0, 1);

      // frame arriving during RESP_WAIT is held until the response completes
      @(negedge clk); cmd_rdy = 1'b1; cmd = 8'h05; data = 16'h0064;
      @(negedge clk); check("busy.clr1", clr_cmd_rdy, 1'b1); cmd_rdy = 1'b0; model_apply(8'h05, 16'h0064);
      @(negedge clk); check("busy.send1", send_resp, 1'b1);
      cmd_rdy = 1'b1; cmd = 8'h03; data = 16'h0032;
      seen = 1'b0;
      repeat (4) begin @(negedge clk); seen |= clr_cmd_rdy; end
      check("busy.no_clr", seen, 1'b0);
      check("busy.roll_old", d_roll, m_roll);
      resp_sent = 1'b1; @(negedge clk); resp_sent = 1'b0;
      check("busy.no_clr_on_exit", clr_cmd_rdy, 1'b0);
      @(negedge clk);
      check("busy.clr2", clr_cmd_rdy, 1'b1);
      cmd_rdy = 1'b0; model_apply(8'h03, 16'h0032);
      check("busy.roll", d_roll, 16'h0032);
      @(negedge clk); check("busy.send2", send_resp, 1'b1); check("busy.resp2", resp, 8'hA5);
      @(negedge clk); resp_sent = 1'b1; @(negedge clk); resp_sent = 1'b0;

      // resp_sent left high: completion needs a fresh rising edge
      resp_sent = 1'b1;
      @(negedge clk); cmd_rdy = 1'b1; cmd = 8'h04; data = 16'h0A0B;
      @(negedge clk); cmd_rdy = 1'b0; model_apply(8'h04, 16'h0A0B);
      @(negedge clk); check("stale.send", send_resp, 1'b1);
      cmd_rdy = 1'b1; cmd = 8'h08; data = 16'h0000;
      seen = 1'b0;
      repeat (4) begin @(negedge clk); seen |= clr_cmd_rdy; end
      check("stale.no_clr", seen, 1'b0);
      resp_sent = 1'b0; @(negedge clk);
      resp_sent = 1'b1; @(negedge clk); resp_sent = 1'b0;
      check("stale.no_clr_exit", clr_cmd_rdy, 1'b0);
      @(negedge clk);
      check("stale.clr", clr_cmd_rdy, 1'b1);
      cmd_rdy = 1'b0; model_apply(8'h08, 16'h0000);
      check_setpoints("stale");
      @(negedge clk); check("stale.resp", resp, 8'hA5);
      @(negedge clk); resp_sent = 1'b1; @(negedge clk); resp_sent = 1'b0;

      // random frames
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         op = (r < 8) ? 8'(r + 1) : 8'($urandom);
         dat = 16'($urandom);
         do_cmd(op, dat, $urandom_range(0, 20), $urandom_range(0, 6));
      end
      check_setpoints("random_end");

`ifdef CMD_TIMEOUT_EN
      do_cmd(8'h06, 16'h0000, 5, 1);
      do_cmd(8'h05, 16'd200, 0, 1);
      while (cyc < clr_cyc + 999) @(negedge clk);
      check("tmo.before_moff", motors_off, 1'b0);
      check("tmo.before_thrst", thrst, 9'd200);
      @(negedge clk);
      check("tmo.moff", motors_off, 1'b1);
      check("tmo.thrst", thrst, 9'd0);
      m_moff = 1'b1; m_thrst = 9'd0;
      repeat (5) @(negedge clk);
      check("tmo.hold", motors_off, 1'b1);
`endif

      // reset in the middle of a calibration
      @(negedge clk); cmd_rdy = 1'b1; cmd = 8'h06; data = 16'h0000;
      @(negedge clk); cmd_rdy = 1'b0;
      check("rstcal.ical", inertial_cal, 1'b1);
      repeat (5) @(negedge clk);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      model_reset();
      check_reset_outputs("rstcal");
      seen = 1'b0;
      cal_done = 1'b1; @(negedge clk); cal_done = 1'b0;
      repeat (5) begin @(negedge clk); seen |= send_resp | inertial_cal; end
      check("rstcal.quiet", seen, 1'b0);
      do_cmd(8'h02, 16'h0101, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
